// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush control for the 5-stage RISC-V pipeline: load-use interlock,
// taken-branch flush, multi-cycle E-stage hold with watchdog, and perf counters.
module pipeline_stall_ctrl #(
    parameter int CNT_W      = 16,
    parameter int MD_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       RS1_D,
    input  logic [4:0]       RS2_D,
    input  logic [4:0]       RD_E,
    input  logic             RegWriteE,
    input  logic             ResultSrcE0,
    input  logic             PCSrcE,
    input  logic             MdStartE,
    input  logic             MdDoneE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             MdTimeout,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    localparam int TMR_W = $clog2(MD_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(MD_TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MD_BUSY = 2'd1,
        MD_ERR  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [TMR_W-1:0] r_timer;
    logic [TMR_W-1:0] w_timer_next;
    logic             r_md_timeout;
    logic             w_timeout_hit;
    logic             w_lw_stall;
    logic             w_md_stall;
    logic [1:0]       w_cnt_inc;
    logic [CNT_W-1:0] r_cnt [2];

    // x0 is hardwired zero, so a load targeting it never creates a dependency.
    assign w_lw_stall = ResultSrcE0 & RegWriteE & (RD_E != 5'd0) &
                        ((RD_E == RS1_D) | (RD_E == RS2_D));

    always_comb begin
        w_state_next  = r_state;
        w_timer_next  = r_timer;
        w_md_stall    = 1'b0;
        w_timeout_hit = 1'b0;
        case (r_state)
            IDLE: begin
                if (MdStartE && !MdDoneE) begin
                    w_state_next = MD_BUSY;
                    w_timer_next = TMR_ONE;
                    w_md_stall   = 1'b1;
                end
            end
            MD_BUSY: begin
                if (MdDoneE) begin
                    w_state_next = IDLE;
                    w_timer_next = '0;
                end else if (r_timer >= TMR_LIMIT) begin
                    // Watchdog expiry: release the pipeline this very cycle.
                    w_state_next  = MD_ERR;
                    w_timer_next  = '0;
                    w_timeout_hit = 1'b1;
                end else begin
                    w_timer_next = r_timer + TMR_ONE;
                    w_md_stall   = 1'b1;
                end
            end
            MD_ERR: begin
                w_state_next = IDLE;
                w_timer_next = '0;
            end
            default: begin
                w_state_next = IDLE;
                w_timer_next = '0;
            end
        endcase
    end

    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        if (!rst) begin
            if (w_md_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
            end else if (PCSrcE) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (w_lw_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_timer      <= '0;
            r_md_timeout <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_timer <= w_timer_next;
            if (w_timeout_hit) begin
                r_md_timeout <= 1'b1;
            end
        end
    end

    assign w_cnt_inc = {FlushD, StallF};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt[gi] <= '0;
                end else if (w_cnt_inc[gi] && (r_cnt[gi] != CNT_MAX)) begin
                    r_cnt[gi] <= r_cnt[gi] + CNT_ONE;
                end
            end
        end
    endgenerate

    assign MdTimeout  = r_md_timeout;
    assign StallCount = r_cnt[0];
    assign FlushCount = r_cnt[1];

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl: a default-parameter instance and a
// small one (CNT_W=3, MD_TIMEOUT=4) driven from the same stimulus.
module tb_pipeline_stall_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] RS1_D, RS2_D, RD_E;
    logic       RegWriteE, ResultSrcE0, PCSrcE, MdStartE, MdDoneE;

    logic        d_sf, d_sd, d_se, d_fd, d_fe, d_tmo;
    logic [15:0] d_scnt, d_fcnt;
    logic        s_sf, s_sd, s_se, s_fd, s_fe, s_tmo;
    logic [2:0]  s_scnt, s_fcnt;
    logic [4:0]  d_ctl, s_ctl;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    assign d_ctl = {d_sf, d_sd, d_se, d_fd, d_fe};
    assign s_ctl = {s_sf, s_sd, s_se, s_fd, s_fe};

    pipeline_stall_ctrl u_dut (
        .clk(clk), .rst(rst), .RS1_D(RS1_D), .RS2_D(RS2_D), .RD_E(RD_E),
        .RegWriteE(RegWriteE), .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
        .MdStartE(MdStartE), .MdDoneE(MdDoneE),
        .StallF(d_sf), .StallD(d_sd), .StallE(d_se), .FlushD(d_fd), .FlushE(d_fe),
        .MdTimeout(d_tmo), .StallCount(d_scnt), .FlushCount(d_fcnt)
    );

    pipeline_stall_ctrl #(.CNT_W(3), .MD_TIMEOUT(4)) u_small (
        .clk(clk), .rst(rst), .RS1_D(RS1_D), .RS2_D(RS2_D), .RD_E(RD_E),
        .RegWriteE(RegWriteE), .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
        .MdStartE(MdStartE), .MdDoneE(MdDoneE),
        .StallF(s_sf), .StallD(s_sd), .StallE(s_se), .FlushD(s_fd), .FlushE(s_fe),
        .MdTimeout(s_tmo), .StallCount(s_scnt), .FlushCount(s_fcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-16s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        RS1_D = 5'd0; RS2_D = 5'd0; RD_E = 5'd0;
        RegWriteE = 1'b0; ResultSrcE0 = 1'b0; PCSrcE = 1'b0;
        MdStartE = 1'b0; MdDoneE = 1'b0;
    endtask

    task automatic set_lw();
        ResultSrcE0 = 1'b1; RegWriteE = 1'b1; RD_E = 5'd5; RS1_D = 5'd3; RS2_D = 5'd5;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clr_in();
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        // Reset: combinational outputs forced low even with hazards present
        rst = 1'b1;
        clr_in();
        cyc();
        set_lw();
        PCSrcE = 1'b1;
        MdStartE = 1'b1;
        cyc();
        #3;
        chk("rst_ctl", 32'(d_ctl), 32'h0);
        chk("rst_ctl_s", 32'(s_ctl), 32'h0);
        chk("rst_scnt", 32'(d_scnt), 32'h0);
        chk("rst_fcnt", 32'(d_fcnt), 32'h0);
        chk("rst_tmo", 32'(d_tmo), 32'h0);
        cyc();
        rst = 1'b0;
        clr_in();

        // Load-use on rs2
        set_lw();
        #3;
        chk("lw_ctl", 32'(d_ctl), 32'b11001);
        cyc();
        chk("lw_scnt", 32'(d_scnt), 32'd1);

        // Same dependency through x0: no stall
        RD_E = 5'd0; RS1_D = 5'd0; RS2_D = 5'd0;
        #3;
        chk("x0_ctl", 32'(d_ctl), 32'h0);
        cyc();
        chk("x0_scnt", 32'(d_scnt), 32'd1);

        // Taken branch beats load-use
        set_lw();
        PCSrcE = 1'b1;
        #3;
        chk("br_ctl", 32'(d_ctl), 32'b00011);
        cyc();
        chk("br_fcnt", 32'(d_fcnt), 32'd1);
        chk("br_scnt", 32'(d_scnt), 32'd1);
        clr_in();

        // Multi-cycle op, done 5 cycles after start; branch/load-use ignored while held
        do_reset();
        MdStartE = 1'b1;
        for (int i = 0; i < 5; i++) begin
            PCSrcE = (i == 2);
            if (i == 3) set_lw();
            #3;
            chk($sformatf("md_hold%0d", i), 32'(d_ctl), 32'b11100);
            cyc();
        end
        clr_in();
        MdStartE = 1'b1;
        MdDoneE = 1'b1;
        #3;
        chk("md_done_ctl", 32'(d_ctl), 32'h0);
        cyc();
        chk("md_scnt", 32'(d_scnt), 32'd5);
        chk("md_fcnt", 32'(d_fcnt), 32'd0);

        // Back-to-back op right after returning to IDLE
        MdDoneE = 1'b0;
        #3;
        chk("b2b_ctl", 32'(d_ctl), 32'b11100);
        cyc();
        MdDoneE = 1'b1;
        #3;
        chk("b2b_done", 32'(d_ctl), 32'h0);
        cyc();

        // Single-cycle op (start and done together) stays IDLE
        #3;
        chk("sc_ctl", 32'(d_ctl), 32'h0);
        cyc();
        MdStartE = 1'b0;
        MdDoneE = 1'b0;
        #3;
        chk("sc_idle", 32'(d_ctl), 32'h0);
        cyc();
        chk("sc_scnt", 32'(d_scnt), 32'd6);

        // Watchdog on the small instance (MD_TIMEOUT=4)
        do_reset();
        MdStartE = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #3;
            chk($sformatf("to_hold%0d", i), 32'(s_ctl), 32'b11100);
            chk($sformatf("to_tmo%0d", i), 32'(s_tmo), 32'h0);
            cyc();
        end
        #3;
        chk("to_rel_s", 32'(s_ctl), 32'h0);
        chk("to_hold_d", 32'(d_ctl), 32'b11100);
        cyc();
        chk("to_tmo_set", 32'(s_tmo), 32'h1);
        chk("to_tmo_d", 32'(d_tmo), 32'h0);
        MdStartE = 1'b0;
        MdDoneE = 1'b1;
        #3;
        chk("to_err_ctl", 32'(s_ctl), 32'h0);
        chk("to_d_rel", 32'(d_ctl), 32'h0);
        cyc();
        MdDoneE = 1'b0;
        #3;
        chk("to_idle_ctl", 32'(s_ctl), 32'h0);
        chk("to_tmo_stk", 32'(s_tmo), 32'h1);
        chk("to_scnt", 32'(s_scnt), 32'd4);
        cyc();
        chk("to_tmo_stk2", 32'(s_tmo), 32'h1);
        do_reset();
        chk("to_tmo_clr", 32'(s_tmo), 32'h0);

        // Reset in the middle of MD_BUSY
        MdStartE = 1'b1;
        cyc();
        cyc();
        rst = 1'b1;
        PCSrcE = 1'b1;
        #3;
        chk("mrst_ctl_d", 32'(d_ctl), 32'h0);
        chk("mrst_ctl_s", 32'(s_ctl), 32'h0);
        cyc();
        rst = 1'b0;
        clr_in();
        #3;
        chk("mrst_idle_d", 32'(d_ctl), 32'h0);
        chk("mrst_idle_s", 32'(s_ctl), 32'h0);
        chk("mrst_tmo", 32'(s_tmo), 32'h0);
        chk("mrst_scnt", 32'(s_scnt), 32'd0);
        cyc();

        // Counter saturation: 10 load-use stalls
        set_lw();
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk($sformatf("sat_s%0d", i), 32'(s_scnt), (i + 1 > 7) ? 32'd7 : 32'(i + 1));
            chk($sformatf("sat_d%0d", i), 32'(d_scnt), 32'(i + 1));
        end
        clr_in();
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
- Stall/flush control for the 5-stage RISC-V pipeline; complements the E-stage forwarding logic.
- Covers the hazards forwarding cannot resolve:
  - load-use: stall F/D, bubble into E;
  - taken branch/jump: flush D/E;
  - multi-cycle E-stage ops (mul/div): hold F/D/E until done, with a timeout watchdog.
- Also keeps saturating stall/flush performance counters.

Parameters:
CNT_W, 16, width of StallCount/FlushCount
MD_TIMEOUT, 64, max cycles in MD_BUSY before timeout abort (>=2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
RS1_D  in  5  rs1 of instruction in D
RS2_D  in  5  rs2 of instruction in D
RD_E  in  5  rd of instruction in E
RegWriteE  in  1  E instruction writes rd
ResultSrcE0  in  1  E instruction is a load
PCSrcE  in  1  branch/jump taken, resolved in E
MdStartE  in  1  multi-cycle op present in E (asserted while it sits in E)
MdDoneE  in  1  multi-cycle result valid this cycle
StallF  out  1  hold PC
StallD  out  1  hold IF/ID register
StallE  out  1  hold ID/EX register
FlushD  out  1  clear IF/ID register
FlushE  out  1  clear ID/EX register
MdTimeout  out  1  sticky: multi-cycle op timed out
StallCount  out  CNT_W  cycles with StallF=1, saturating
FlushCount  out  CNT_W  cycles with FlushD=1, saturating

Behaviour:
- Reset (rst=1 at clk edge):
  - state=IDLE, timer=0, MdTimeout=0, both counters 0.
  - While rst=1, every combinational output (StallF/D/E, FlushD/E) is forced 0.
  - Reset mid-MD_BUSY aborts the op; no timeout is flagged.
- lwStall = ResultSrcE0 & RegWriteE & (RD_E!=0) & ((RD_E==RS1_D)|(RD_E==RS2_D)). Combinational, same-cycle.
- mdStall = (state==IDLE & MdStartE & !MdDoneE) | (state==MD_BUSY & !MdDoneE & timer<MD_TIMEOUT).
- Output priority, highest first:
  1. mdStall: StallF=StallD=StallE=1, FlushD=FlushE=0. lwStall and PCSrcE are ignored (E is held, so no branch resolves).
  2. PCSrcE: FlushD=FlushE=1, all stalls 0. Branch wins over lwStall, because the loaded-into instruction is discarded.
  3. lwStall: StallF=StallD=1, FlushE=1, StallE=0, FlushD=0.
  4. Otherwise all 0.
- FSM, states IDLE, MD_BUSY, MD_ERR:
  - IDLE:
    - MdStartE & !MdDoneE -> MD_BUSY, timer<=1.
    - MdStartE & MdDoneE same cycle -> single-cycle op; stay IDLE, no stall.
  - MD_BUSY:
    - MdDoneE -> IDLE, timer<=0; stalls drop in that same cycle (zero-latency release).
    - Else timer<=timer+1.
    - When timer==MD_TIMEOUT & !MdDoneE -> MD_ERR; stalls already 0 that cycle; MdTimeout<=1.
  - MD_ERR: lasts one cycle, no stall, then IDLE. The held op proceeds with an undefined result; the trap is raised by software via MdTimeout.
  - MdTimeout stays 1 until rst.
  - Worst-case stall per op is MD_TIMEOUT cycles.
- Back-to-back ops: MdStartE in the cycle after return to IDLE starts a new op normally.
- Counters:
  - StallCount += 1 in each non-reset cycle with StallF=1.
  - FlushCount += 1 in each cycle with FlushD=1.
  - Both hold at 2^CNT_W-1 (no wrap).
- rd=x0 never causes a load-use stall.

Test Plan:
- Load x5 in E (ResultSrcE0=1, RegWriteE=1, RD_E=5), RS2_D=5 -> StallF=StallD=FlushE=1 for that cycle; StallCount=1 after the edge. Repeat with RD_E=0 -> all outputs 0.
- PCSrcE=1 together with the load-use condition above -> FlushD=FlushE=1, StallF=StallD=0; FlushCount increments by 1, StallCount unchanged.
- MdStartE=1, MdDoneE rising 5 cycles later -> StallF/D/E=1 for exactly 5 cycles, 0 in the done cycle; FSM returns to IDLE; StallCount=5.
- MdStartE=1 with MdDoneE=1 in the same cycle -> no stall; FSM stays IDLE.
- MD_TIMEOUT=4, MdDoneE never asserted:
  - stalls are 1 for cycles 0..3 and 0 in cycle 4;
  - MdTimeout=1 from the next cycle and stays 1;
  - a later rst clears it.
- CNT_W=3, 10 consecutive load-use stalls -> StallCount saturates at 7. rst asserted mid-MD_BUSY -> all outputs 0 during reset, state IDLE afterwards, MdTimeout=0.
